// File: rtl/seg7_pkg.sv
// Shared constants for the result display: segment codes, blank digit code and FSM encoding.
package seg7_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        code = SEG_BLANK;
        case (digit)
            4'd0: code = 7'h40;
            4'd1: code = 7'h79;
            4'd2: code = 7'h24;
            4'd3: code = 7'h30;
            4'd4: code = 7'h19;
            4'd5: code = 7'h12;
            4'd6: code = 7'h02;
            4'd7: code = 7'h78;
            4'd8: code = 7'h00;
            4'd9: code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin8_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), with sign/magnitude capture.
module bin8_to_bcd_seq
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       signed_mode,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state, state_nxt;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [2:0]  shift_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONVERT;
            CONVERT: if (shift_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            neg       <= 1'b0;
        end else if (state == IDLE && load) begin
            // Negative two's complement values are shown as sign plus magnitude; 0x80 yields 128.
            if (signed_mode && value[7]) begin
                mag <= ~value + 8'd1;
                neg <= 1'b1;
            end else begin
                mag <= value;
                neg <= 1'b0;
            end
            bcd       <= '0;
            shift_cnt <= '0;
        end else if (state == CONVERT) begin
            {bcd, mag} <= {bcd_adj, mag} << 1;
            shift_cnt  <= shift_cnt + 3'd1;
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

endmodule

// File: rtl/seg7_result_display.sv
// Shows the 8-bit calculator result in decimal on a 4-digit multiplexed common-anode display.
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       signed_mode,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam logic [REFRESH_BITS-1:0] CNT_ONE = 1;

    logic                    done;
    logic                    neg;
    logic [3:0]              hundreds, tens, ones;
    logic [3:0]              dig_h, dig_t, dig_o;
    logic                    sign_q;
    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0]              sel;
    logic [6:0]              seg_nxt;
    logic [3:0]              an_nxt;

    bin8_to_bcd_seq u_conv (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .signed_mode (signed_mode),
        .load        (load),
        .busy        (busy),
        .done        (done),
        .neg         (neg),
        .hundreds    (hundreds),
        .tens        (tens),
        .ones        (ones)
    );

    // Display digits change only on the commit cycle, so a running conversion never shows partial results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_h  <= BCD_BLANK;
            dig_t  <= BCD_BLANK;
            dig_o  <= BCD_BLANK;
            sign_q <= 1'b0;
        end else if (done) begin
            dig_h  <= (hundreds == 4'd0) ? BCD_BLANK : hundreds;
            dig_t  <= (hundreds == 4'd0 && tens == 4'd0) ? BCD_BLANK : tens;
            dig_o  <= ones;
            sign_q <= neg;
        end
    end

    assign sel = cnt[REFRESH_BITS-1 -: 2];

    always_comb begin
        seg_nxt = SEG_BLANK;
        an_nxt  = 4'hF;
        case (sel)
            2'd0: begin seg_nxt = seg_decode(dig_o); an_nxt = 4'b1110; end
            2'd1: begin seg_nxt = seg_decode(dig_t); an_nxt = 4'b1101; end
            2'd2: begin seg_nxt = seg_decode(dig_h); an_nxt = 4'b1011; end
            default: begin
                seg_nxt = sign_q ? SEG_MINUS : SEG_BLANK;
                an_nxt  = 4'b0111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            seg <= SEG_BLANK;
            an  <= 4'hF;
        end else begin
            cnt <= cnt + CNT_ONE;
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_result_display.sv
// Directed self-checking bench for seg7_result_display with a short scan counter.
module tb_seg7_result_display;

    logic       clk;
    logic       rst_n;
    logic [7:0] value;
    logic       signed_mode;
    logic       load;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] segs [4];

    seg7_result_display #(.REFRESH_BITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .signed_mode (signed_mode),
        .load        (load),
        .busy        (busy),
        .seg         (seg),
        .an          (an),
        .dp          (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse load for one rising edge; returns at the negedge just after that edge.
    task automatic pulse_load(input logic [7:0] v, input logic s);
        @(negedge clk);
        value = v; signed_mode = s; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Waits for the scan to enter digit 0, then records seg for each digit and checks the anode order.
    task automatic capture_display(input string name);
        logic [3:0] prev_an;
        logic [3:0] exp_an;
        bit found = 0;
        bit an_ok = 1;
        prev_an = an;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev_an != 4'b1110) found = 1;
            prev_an = an;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL %s_scan_sync: an=%b never entered 1110 within 64 cycles", name, an);
            return;
        end
        for (int k = 0; k < 16; k++) begin
            exp_an = ~(4'b0001 << (k / 4));
            if (an !== exp_an) an_ok = 0;
            if (k % 4 == 1) segs[k / 4] = seg;
            @(negedge clk);
        end
        n_cmp++;
        if (!an_ok) begin
            n_bad++;
            $display("FAIL %s_an_order: scan sequence deviated, last an=%b", name, an);
        end
    endtask

    task automatic check_digits(input string name, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] exp [4];
        exp[3] = e3; exp[2] = e2; exp[1] = e1; exp[0] = e0;
        capture_display(name);
        for (int d = 3; d >= 0; d--) begin
            n_cmp++;
            if (segs[d] !== exp[d]) begin
                n_bad++;
                $display("FAIL %s_digit%0d: seg=%h expected %h", name, d, segs[d], exp[d]);
            end
        end
    endtask

    // Counts busy samples starting at the negedge right after the load edge.
    task automatic busy_length(input string name, input int expected);
        int high = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) high++;
            @(negedge clk);
        end
        n_cmp++;
        if (high !== expected) begin
            n_bad++;
            $display("FAIL %s_busy_len: busy high %0d cycles, expected %0d", name, high, expected);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; value = '0; signed_mode = 1'b0; load = 1'b0;
        #23;
        n_cmp++;
        if ({busy, seg, an, dp} !== {1'b0, 7'h7F, 4'hF, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b seg=%h an=%b dp=%b expected 0 7f 1111 1", busy, seg, an, dp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (an !== 4'b1110) begin
            n_bad++;
            $display("FAIL reset_first_an: an=%b expected 1110", an);
        end
        check_digits("blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    endtask

    task automatic test_unsigned_255();
        pulse_load(8'd255, 1'b0);
        busy_length("u255", 9);
        check_digits("u255", 7'h7F, 7'h24, 7'h12, 7'h12);
        n_cmp++;
        if (dp !== 1'b1) begin
            n_bad++;
            $display("FAIL dp_off: dp=%b expected 1", dp);
        end
    endtask

    task automatic test_signed_min();
        pulse_load(8'h80, 1'b1);
        busy_length("s128", 9);
        check_digits("s128", 7'h3F, 7'h79, 7'h24, 7'h00);
    endtask

    task automatic test_signed_small();
        pulse_load(8'hF9, 1'b1);
        busy_length("s7", 9);
        check_digits("s7", 7'h3F, 7'h7F, 7'h7F, 7'h78);
    endtask

    task automatic test_zero();
        pulse_load(8'd0, 1'b0);
        busy_length("zero", 9);
        check_digits("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40);
    endtask

    task automatic test_back_to_back();
        pulse_load(8'd42, 1'b0);
        repeat (2) @(negedge clk);
        value = 8'd99; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_busy_end: busy=%b expected 0 ten cycles after first load", busy);
        end
        check_digits("b2b", 7'h7F, 7'h7F, 7'h19, 7'h24);
    endtask

    task automatic test_reset_mid_conversion();
        pulse_load(8'd100, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, seg, an} !== {1'b0, 7'h7F, 4'hF}) begin
            n_bad++;
            $display("FAIL midreset_async: busy=%b seg=%h an=%b expected 0 7f 1111", busy, seg, an);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_digits("midreset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    endtask

    initial begin
        test_reset();
        test_unsigned_255();
        test_signed_min();
        test_signed_small();
        test_zero();
        test_back_to_back();
        test_reset_mid_conversion();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
